alu_issue_ctrl: RTL and testbench

Issue and writeback stage wrapped around the 16-bit ALU. It owns an 8-entry × 16-bit register file and a Z/N flag register, and accepts instructions over a valid/ready handshake. For each accepted instruction it reads the operands, drives the ALU's `inA`, `inB`, `opc` and `inC` inputs from registers, then writes the ALU result `w` and flags (`zer`, `neg`) back. A host write port loads data into the register file.

---
 rtl/alu_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around the 16-bit ALU: 4-cycle IDLE->FETCH->EXEC->WB walk, 8x16 regfile, Z/N flags.
// in_ready is low from accept until WB retires; ALU_ISSUE_NOP7_EN turns opc 7 into a no-writeback NOP.
module alu_issue_ctrl #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [12:0]   in_instr,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [2:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] alu_inA,
  output logic [DW-1:0] alu_inB,
  output logic [2:0]    alu_opc,
  output logic          alu_inC,
  input  logic [DW-1:0] alu_w,
  input  logic          alu_zer,
  input  logic          alu_neg,
  output logic          flag_z,
  output logic          flag_n,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  state_t        r_state;
  logic [12:0]   r_ir;
  logic [DW-1:0] r_res;
  logic          r_res_z;
  logic          r_res_n;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [2:0]    r_alu_opc;
  logic          r_alu_c;
  logic          r_flag_z;
  logic          r_flag_n;
  logic [DW-1:0] r_regs [NREG];

  logic [2:0] w_opc;
  logic       w_cin;
  logic [2:0] w_dst;
  logic [2:0] w_srca;
  logic [2:0] w_srcb;
  logic       w_is_nop;
  logic       w_wb_commit;

  assign w_opc  = r_ir[12:10];
  assign w_cin  = r_ir[9];
  assign w_dst  = r_ir[8:6];
  assign w_srca = r_ir[5:3];
  assign w_srcb = r_ir[2:0];

`ifdef ALU_ISSUE_NOP7_EN
  assign w_is_nop = (w_opc == 3'd7);
`else
  assign w_is_nop = 1'b0;
`endif

  assign w_wb_commit = (r_state == ST_WB) && !w_is_nop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ir       <= '0;
      r_res      <= '0;
      r_res_z    <= 1'b0;
      r_res_n    <= 1'b0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_opc  <= '0;
      r_alu_c    <= 1'b0;
      r_flag_z   <= 1'b0;
      r_flag_n   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_ir       <= in_instr;
            r_state    <= ST_FETCH;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_FETCH: begin
          // Operands are sampled pre-edge, so a host write landing on this edge is not seen.
          r_alu_a   <= r_regs[w_srca];
          r_alu_b   <= r_regs[w_srcb];
          r_alu_opc <= w_opc;
          r_alu_c   <= w_cin;
          r_state   <= ST_EXEC;
        end
        ST_EXEC: begin
          r_res   <= alu_w;
          r_res_z <= alu_zer;
          r_res_n <= alu_neg;
          r_done  <= 1'b1;
          r_state <= ST_WB;
        end
        ST_WB: begin
          if (w_wb_commit) begin
            r_flag_z <= r_res_z;
            r_flag_n <= r_res_n;
          end
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Writeback takes priority over a host write to the same entry on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wb_commit && (w_dst == 3'(i))) begin
          r_regs[i] <= r_res;
        end else if (wr_en && (wr_addr == 3'(i))) begin
          r_regs[i] <= wr_data;
        end
      end
    end
  end

  assign rd_data  = r_regs[rd_addr];
  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign alu_inA  = r_alu_a;
  assign alu_inB  = r_alu_b;
  assign alu_opc  = r_alu_opc;
  assign alu_inC  = r_alu_c;
  assign flag_z   = r_flag_z;
  assign flag_n   = r_flag_n;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table, hand-written corner sequences, and random traffic vs a regfile model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_instr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] alu_inA;
  logic [15:0] alu_inB;
  logic [2:0]  alu_opc;
  logic        alu_inC;
  logic [15:0] alu_w;
  logic        alu_zer;
  logic        alu_neg;
  logic        flag_z;
  logic        flag_n;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NREG(8), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_opc(alu_opc), .alu_inC(alu_inC),
    .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
    .flag_z(flag_z), .flag_n(flag_n), .busy(busy), .done(done)
  );

`ifdef ALU_ISSUE_NOP7_EN
  localparam bit NOP7 = 1'b1;
`else
  localparam bit NOP7 = 1'b0;
`endif

  // Behavioural ALU: opc 7 always yields zero.
  function automatic logic [15:0] ref_alu(input logic [2:0] opc, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
    case (opc)
      3'd0:    return a + b + {15'd0, c};
      3'd1:    return a - b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return a & b;
      3'd5:    return a;
      3'd6:    return ~b;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_w   = ref_alu(alu_opc, alu_inA, alu_inB, alu_inC);
  assign alu_zer = (alu_w == 16'h0000);
  assign alu_neg = alu_w[15];

  logic [15:0] mregs [8];
  logic        mz;
  logic        mn;
  int          nvec = 0;
  int          nerr = 0;

  typedef struct {
    logic [12:0] instr;
    logic [15:0] exp_res;
    logic        exp_z;
    logic        exp_n;
  } vec_t;

  vec_t vt [9];

  function automatic logic [12:0] mk(input int opc, input int cin, input int dst,
                                     input int a, input int b);
    return {3'(opc), 1'(cin), 3'(dst), 3'(a), 3'(b)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input logic [2:0] a, input logic [15:0] e, input string nm);
    rd_addr = a;
    #1;
    chk(nm, {16'd0, rd_data}, {16'd0, e});
  endtask

  task automatic host_write(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mregs[a] = d;
  endtask

  // Issue one instruction; optional host write lands at edge hw_edge (1=FETCH, 2=EXEC, 3=WB).
  task automatic issue(input logic [12:0] ins, input logic [15:0] exp_res, input logic exp_z,
                       input logic exp_n, input bit commit, input int hw_edge,
                       input logic [2:0] hw_a, input logic [15:0] hw_d, input string nm);
    int guard;
    logic [2:0] dst;
    logic [2:0] sa;
    logic [2:0] sb;
    dst = ins[8:6]; sa = ins[5:3]; sb = ins[2:0];
    in_valid = 1'b1; in_instr = ins; guard = 0;
    while (!in_ready && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      chk({nm, " accept timeout"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_instr = 13'($urandom);
    chk({nm, " busy@fetch"}, {31'd0, busy}, 32'd1);
    chk({nm, " ready@fetch"}, {31'd0, in_ready}, 32'd0);
    for (int e = 1; e <= 3; e++) begin
      if (hw_edge == e) begin
        wr_en = 1'b1; wr_addr = hw_a; wr_data = hw_d;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (e == 1) begin
        chk({nm, " inA"}, {16'd0, alu_inA}, {16'd0, mregs[sa]});
        chk({nm, " inB"}, {16'd0, alu_inB}, {16'd0, mregs[sb]});
        chk({nm, " opc"}, {29'd0, alu_opc}, {29'd0, ins[12:10]});
        chk({nm, " inC"}, {31'd0, alu_inC}, {31'd0, ins[9]});
        chk({nm, " done@exec"}, {31'd0, done}, 32'd0);
      end
      if (e == 2) chk({nm, " done@wb"}, {31'd0, done}, 32'd1);
    end
    in_valid = 1'b0;
    if (hw_edge > 0) mregs[hw_a] = hw_d;
    if (commit) begin
      mregs[dst] = exp_res; mz = exp_z; mn = exp_n;
    end
    chk({nm, " done@idle"}, {31'd0, done}, 32'd0);
    chk({nm, " ready@idle"}, {31'd0, in_ready}, 32'd1);
    chk({nm, " flag_z"}, {31'd0, flag_z}, {31'd0, mz});
    chk({nm, " flag_n"}, {31'd0, flag_n}, {31'd0, mn});
    chk_reg(dst, mregs[dst], {nm, " dst"});
    if (hw_edge > 0) chk_reg(hw_a, mregs[hw_a], {nm, " hostreg"});
  endtask

  function automatic void model_exec(input logic [12:0] ins);
    logic [15:0] r;
    r = ref_alu(ins[12:10], mregs[ins[5:3]], mregs[ins[2:0]], ins[9]);
    if (!(NOP7 && ins[12:10] == 3'd7)) begin
      mregs[ins[8:6]] = r; mz = (r == 16'h0000); mn = r[15];
    end
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lowcnt;
    logic [12:0] ins;
    logic [15:0] er;
    logic [12:0] i1;
    logic [12:0] i2;

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    mz = 1'b0; mn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst flags", {30'd0, flag_z, flag_n}, 32'd0);
    chk("rst alu", {alu_inA, alu_inB} ^ {28'd0, alu_opc, alu_inC}, 32'd0);
    for (int i = 0; i < 8; i++) chk_reg(3'(i), 16'h0000, "rst reg");
    @(posedge clk); #1;

    vt[0] = '{mk(0, 1, 3, 1, 2), 16'h0009, 1'b0, 1'b0};
    vt[1] = '{mk(6, 0, 4, 0, 0), 16'hFFFF, 1'b0, 1'b1};
    vt[2] = '{mk(4, 0, 7, 5, 6), 16'h0000, 1'b1, 1'b0};
    vt[3] = '{mk(1, 0, 7, 2, 1), 16'hFFFE, 1'b0, 1'b1};
    vt[4] = '{mk(3, 1, 7, 5, 5), 16'h0000, 1'b1, 1'b0};
    vt[5] = '{mk(2, 0, 7, 5, 6), 16'h0FF0, 1'b0, 1'b0};
    vt[6] = '{mk(5, 0, 7, 3, 0), 16'h0009, 1'b0, 1'b0};
    vt[7] = '{mk(0, 1, 4, 4, 1), 16'h0005, 1'b0, 1'b0};
    vt[8] = '{mk(1, 0, 6, 6, 6), 16'h0000, 1'b1, 1'b0};

    host_write(3'd0, 16'h0000);
    host_write(3'd1, 16'h0005);
    host_write(3'd2, 16'h0003);
    host_write(3'd5, 16'h00F0);
    host_write(3'd6, 16'h0F00);
    for (int v = 0; v < 9; v++) begin
      issue(vt[v].instr, vt[v].exp_res, vt[v].exp_z, vt[v].exp_n, 1'b1, 0, 3'd0, 16'h0,
            $sformatf("vec%0d", v));
    end

    host_write(3'd3, 16'h7777);
    issue(mk(0, 1, 3, 1, 2), 16'h0009, 1'b0, 1'b0, 1'b1, 3, 3'd3, 16'h1234, "wb collision");
    issue(mk(5, 0, 7, 1, 0), 16'h0005, 1'b0, 1'b0, 1'b1, 1, 3'd1, 16'h0100, "fetch hostwr");

    // Back-to-back with in_valid held; second instruction reads the first's result.
    i1 = mk(0, 0, 5, 1, 2);
    i2 = mk(1, 0, 6, 5, 1);
    in_valid = 1'b1; in_instr = i1;
    @(posedge clk); #1;
    in_instr = i2;
    lowcnt = 0;
    while (!in_ready && lowcnt < 8) begin
      lowcnt++;
      chk("b2b busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    chk("b2b ready low cycles", lowcnt, 32'd3);
    model_exec(i1);
    chk_reg(3'd5, mregs[5], "b2b first dst");
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b second accept", {31'd0, in_ready}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    model_exec(i2);
    chk_reg(3'd6, mregs[6], "b2b second dst");
    chk("b2b flag_n", {31'd0, flag_n}, {31'd0, mn});

    // Asynchronous reset while in EXEC.
    in_valid = 1'b1; in_instr = mk(0, 0, 2, 1, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst alu_inA", {16'd0, alu_inA}, {16'd0, mregs[1]});
    rst_n = 1'b0;
    #1;
    chk("mid-rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid-rst busy", {31'd0, busy}, 32'd0);
    chk("mid-rst done", {31'd0, done}, 32'd0);
    chk("mid-rst flags", {30'd0, flag_z, flag_n}, 32'd0);
    chk("mid-rst alu", {alu_inA, alu_inB} ^ {28'd0, alu_opc, alu_inC}, 32'd0);
    for (int i = 0; i < 8; i++) chk_reg(3'(i), 16'h0000, "mid-rst reg");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    mz = 1'b0; mn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reg(3'd2, 16'h0000, "post-rst no wb");
    chk("post-rst done", {31'd0, done}, 32'd0);

    host_write(3'd2, 16'h00AA);
    issue(mk(7, 0, 2, 3, 4), 16'h0000, 1'b1, 1'b0, !NOP7, 0, 3'd0, 16'h0, "opc7");

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) host_write(3'($urandom), 16'($urandom));
      ins = 13'($urandom);
      er  = ref_alu(ins[12:10], mregs[ins[5:3]], mregs[ins[2:0]], ins[9]);
      issue(ins, er, er == 16'h0000, er[15], !(NOP7 && ins[12:10] == 3'd7),
            int'($urandom_range(0, 3)), 3'($urandom), 16'($urandom), $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
